// File: rtl/ghffe_pkg.sv
// Shared types and defaults for the note scheduling path.
package ghffe_pkg;

  localparam int TIME_W_DEF = 16;
  localparam int FRET_W_DEF = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

  // One chart record at default widths ("time" is reserved, hence ntime).
  typedef struct packed {
    logic [FRET_W_DEF-1:0] fret;
    logic [TIME_W_DEF-1:0] ntime;
  } note_rec_t;

endpackage

// File: rtl/note_fifo.sv
// Synchronous DEPTH-entry record buffer. The head entry is read
// combinationally so the scheduler can compare it against song_time in the
// same cycle it decides to pop. Pushes while full and pops while empty are
// ignored.
module note_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 21
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^AW).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset discards all buffered entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/note_scheduler.sv
// Note scheduler: buffers chart records from the loader and releases each
// one as a single-cycle strobe once song_time + LOOKAHEAD reaches its time.
// Optional build macro NOTE_SCHED_LATE_CNT_EN adds a saturating late_count
// output counting notes released after their time had already passed.
module note_scheduler
  import ghffe_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int TIME_W    = TIME_W_DEF,
  parameter int FRET_W    = FRET_W_DEF,
  parameter int LOOKAHEAD = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pause,
  input  logic [TIME_W-1:0]        song_time,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FRET_W-1:0]        in_fret,
  input  logic [TIME_W-1:0]        in_time,
  input  logic                     in_last,
  output logic                     metadata_request,
  output logic                     en,
  output logic [FRET_W-1:0]        fret,
  output logic [TIME_W-1:0]        note_time,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     song_done,
  output logic                     order_err
`ifdef NOTE_SCHED_LATE_CNT_EN
  ,
  output logic [7:0]               late_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]   HALF_CNT = CW'(DEPTH / 2);
  localparam logic [TIME_W:0] LA       = (TIME_W+1)'(LOOKAHEAD);

  sched_state_t       state_q, state_d;
  logic               last_seen_q, last_seen_d;
  logic [TIME_W-1:0]  prev_time_q, prev_time_d;
  logic               order_err_q, order_err_d;
  logic               en_q, en_d;
  logic [FRET_W-1:0]  fret_q, fret_d;
  logic [TIME_W-1:0]  note_time_q, note_time_d;

  logic [FRET_W+TIME_W-1:0] head_data;
  logic [FRET_W-1:0]        head_fret;
  logic [TIME_W-1:0]        head_time;
  logic                     fifo_full, fifo_empty;
  logic [CW-1:0]            fifo_count;

  logic handshake, in_order, push, pop, due, releasing_state;

  note_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (FRET_W + TIME_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data ({in_fret, in_time}),
    .rd_data (head_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign head_fret = head_data[FRET_W+TIME_W-1:TIME_W];
  assign head_time = head_data[TIME_W-1:0];

  // Full is taken from the registered count, so a same-cycle pop never
  // frees a slot for a push.
  assign in_ready  = !fifo_full && (state_q != IDLE) && (state_q != DONE) && !last_seen_q;
  assign handshake = in_valid && in_ready;
  // Equal times are legal: chords may arrive split across records.
  assign in_order  = (in_time >= prev_time_q);
  assign push      = handshake && in_order;

  // One bit wider than song_time so the lookahead sum cannot wrap.
  assign due             = (({1'b0, song_time} + LA) >= {1'b0, head_time});
  assign releasing_state = (state_q == RUN) || (state_q == DRAIN);
  assign pop             = !fifo_empty && !pause && releasing_state && due;

  assign en        = en_q;
  assign fret      = fret_q;
  assign note_time = note_time_q;
  assign count     = fifo_count;
  assign order_err = order_err_q;
  assign song_done = (state_q == DONE);

  // Loader request level: always in FILL, refill below half in RUN.
  always_comb begin
    metadata_request = 1'b0;
    case (state_q)
      FILL:    metadata_request = 1'b1;
      RUN:     metadata_request = (fifo_count < HALF_CNT) && !last_seen_q;
      default: metadata_request = 1'b0;
    endcase
  end

  // Next-state logic for the scheduler FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = FILL;
      FILL:  if ((handshake && in_last) || (fifo_count == FULL_CNT)) state_d = RUN;
      // last_seen may already be set when FILL ended on the final record.
      RUN:   if ((handshake && in_last) || last_seen_q) state_d = DRAIN;
      DRAIN: if (fifo_empty && !push) state_d = DONE;
      DONE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Record bookkeeping and the registered release strobe.
  always_comb begin
    last_seen_d = last_seen_q | (handshake & in_last);
    prev_time_d = push ? in_time : prev_time_q;
    order_err_d = order_err_q | (handshake & ~in_order);
    en_d        = pop;
    fret_d      = fret_q;
    note_time_d = note_time_q;
    if (pop) begin
      fret_d      = head_fret;
      note_time_d = head_time;
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_seen_q <= 1'b0;
      prev_time_q <= '0;
      order_err_q <= 1'b0;
      en_q        <= 1'b0;
      fret_q      <= '0;
      note_time_q <= '0;
    end else begin
      state_q     <= state_d;
      last_seen_q <= last_seen_d;
      prev_time_q <= prev_time_d;
      order_err_q <= order_err_d;
      en_q        <= en_d;
      fret_q      <= fret_d;
      note_time_q <= note_time_d;
    end
  end

`ifdef NOTE_SCHED_LATE_CNT_EN
  logic [7:0] late_cnt_q, late_cnt_d;

  assign late_count = late_cnt_q;

  // Count releases of notes already past due, saturating at 255.
  always_comb begin
    late_cnt_d = late_cnt_q;
    if (pop && (head_time < song_time) && (late_cnt_q != 8'hFF))
      late_cnt_d = late_cnt_q + 8'd1;
  end

  // Late counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) late_cnt_q <= 8'd0;
    else       late_cnt_q <= late_cnt_d;
  end
`endif

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler at DEPTH=4: table-driven cycle vectors
// plus hand-written reset, pause and mid-drain reset sequences.
module tb_note_scheduler;
  import ghffe_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pause = 1'b0;
  logic [15:0] song_time = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_fret = '0;
  logic [15:0] in_time = '0;
  logic        in_last = 1'b0;
  logic        metadata_request;
  logic        en;
  logic [4:0]  fret;
  logic [15:0] note_time;
  logic [2:0]  count;
  logic        song_done;
  logic        order_err;
`ifdef NOTE_SCHED_LATE_CNT_EN
  logic [7:0]  late_count;
`endif

  note_scheduler #(
    .DEPTH     (DEPTH),
    .TIME_W    (16),
    .FRET_W    (5),
    .LOOKAHEAD (1000)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pause            (pause),
    .song_time        (song_time),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_fret          (in_fret),
    .in_time          (in_time),
    .in_last          (in_last),
    .metadata_request (metadata_request),
    .en               (en),
    .fret             (fret),
    .note_time        (note_time),
    .count            (count),
    .song_done        (song_done),
    .order_err        (order_err)
`ifdef NOTE_SCHED_LATE_CNT_EN
    ,
    .late_count       (late_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pause;
    logic [15:0] st;
    logic        vld;
    note_rec_t   rec;
    logic        last;
    logic        e_en;
    note_rec_t   e_rec;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic        e_mreq;
    logic        e_done;
    logic        e_oerr;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic p, input logic [15:0] st,
                              input logic vld, input logic [4:0] fr,
                              input logic [15:0] tm, input logic last,
                              input logic e_en, input logic [4:0] e_fr,
                              input logic [15:0] e_tm, input logic [2:0] e_cnt,
                              input logic e_rdy, input logic e_mreq,
                              input logic e_done, input logic e_oerr);
    vec_t v;
    v.pause = p;   v.st = st;   v.vld = vld;
    v.rec.fret = fr; v.rec.ntime = tm; v.last = last;
    v.e_en = e_en; v.e_rec.fret = e_fr; v.e_rec.ntime = e_tm;
    v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_mreq = e_mreq;
    v.e_done = e_done; v.e_oerr = e_oerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one vector, clock it, then compare outputs 1 ns after the edge.
  task automatic apply(input vec_t v, input string tag);
    pause     = v.pause;
    song_time = v.st;
    in_valid  = v.vld;
    in_fret   = v.rec.fret;
    in_time   = v.rec.ntime;
    in_last   = v.last;
    @(posedge clk);
    #1;
    $display("%s: st=%0d vld=%0d t=%0d -> en=%0d nt=%0d fr=%0d cnt=%0d rdy=%0d mreq=%0d done=%0d oerr=%0d",
             tag, v.st, v.vld, v.rec.ntime, en, note_time, fret, count, in_ready,
             metadata_request, song_done, order_err);
    check({tag, " en"}, 32'(en), 32'(v.e_en));
    if (v.e_en) begin
      check({tag, " note_time"}, 32'(note_time), 32'(v.e_rec.ntime));
      check({tag, " fret"}, 32'(fret), 32'(v.e_rec.fret));
    end
    check({tag, " count"}, 32'(count), 32'(v.e_cnt));
    check({tag, " in_ready"}, 32'(in_ready), 32'(v.e_rdy));
    check({tag, " mreq"}, 32'(metadata_request), 32'(v.e_mreq));
    check({tag, " song_done"}, 32'(song_done), 32'(v.e_done));
    check({tag, " order_err"}, 32'(order_err), 32'(v.e_oerr));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " en"}, 32'(en), 0);
    check({tag, " fret"}, 32'(fret), 0);
    check({tag, " note_time"}, 32'(note_time), 0);
    check({tag, " count"}, 32'(count), 0);
    check({tag, " in_ready"}, 32'(in_ready), 0);
    check({tag, " mreq"}, 32'(metadata_request), 0);
    check({tag, " song_done"}, 32'(song_done), 0);
    check({tag, " order_err"}, 32'(order_err), 0);
  endtask

  // Hold reset across an edge, verify reset values, release it mid-cycle.
  task automatic do_reset(input string tag);
    reset = 1'b1; pause = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    song_time = '0; in_fret = '0; in_time = '0;
    @(posedge clk);
    #1;
    check_reset_outputs(tag);
    reset = 1'b0;
    #1;
    $display("%s: reset released, in_ready=%0d", tag, in_ready);
    check({tag, " idle in_ready"}, 32'(in_ready), 0);
  endtask

  task automatic run_range(input int first, input int last_i, input string tag);
    for (int i = first; i <= last_i; i++) apply(vecs[i], $sformatf("%s[%0d]", tag, i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, c;
    // Fill / release / push-with-pop / empty / lookahead          p  st    v fr  tm   l  en fr  tm   c rdy mq dn oe
    vecs.push_back(mk(0,    0, 0,  0,    0, 0, 0,  0,    0, 0, 1, 1, 0, 0)); // 0 IDLE->FILL
    vecs.push_back(mk(0,    0, 1,  1,  100, 0, 0,  0,    0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0,    0, 1,  2,  200, 0, 0,  0,    0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(0,    0, 1,  4,  300, 0, 0,  0,    0, 3, 1, 1, 0, 0));
    vecs.push_back(mk(0,    0, 1,  8,  400, 0, 0,  0,    0, 4, 0, 1, 0, 0)); // full, still FILL
    vecs.push_back(mk(0,    0, 0,  0,    0, 0, 0,  0,    0, 4, 0, 0, 0, 0)); // -> RUN
    vecs.push_back(mk(0,    0, 0,  0,    0, 0, 1,  1,  100, 3, 1, 0, 0, 0));
    vecs.push_back(mk(0,    0, 1, 16,  450, 0, 1,  2,  200, 3, 1, 0, 0, 0)); // push+pop
    vecs.push_back(mk(0,    0, 0,  0,    0, 0, 1,  4,  300, 2, 1, 0, 0, 0));
    vecs.push_back(mk(0,    0, 0,  0,    0, 0, 1,  8,  400, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0,    0, 0,  0,    0, 0, 1, 16,  450, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1500, 0,  0,    0, 0, 0,  0,    0, 0, 1, 1, 0, 0)); // empty
    vecs.push_back(mk(0, 3000, 0,  0,    0, 0, 0,  0,    0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 3999, 1, 19, 5000, 0, 0,  0,    0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 3999, 0,  0,    0, 0, 0,  0,    0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 3999, 0,  0,    0, 0, 0,  0,    0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4000, 0,  0,    0, 0, 1, 19, 5000, 0, 1, 1, 0, 0)); // lookahead edge
    vecs.push_back(mk(0, 4000, 0,  0,    0, 0, 0,  0,    0, 0, 1, 1, 0, 0)); // 17
    a = vecs.size();
    // Order error run
    vecs.push_back(mk(0,    0, 0,  0,    0, 0, 0,  0,    0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0,    0, 1,  1,  500, 0, 0,  0,    0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0,    0, 1,  2,  400, 0, 0,  0,    0, 1, 1, 1, 0, 1)); // dropped
    vecs.push_back(mk(0,    0, 0,  0,    0, 0, 0,  0,    0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0,    0, 0,  0,    0, 0, 0,  0,    0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0,    0, 1,  4,  500, 0, 0,  0,    0, 2, 1, 1, 0, 1)); // equal ok
    b = vecs.size();
    // End-of-song run
    vecs.push_back(mk(0,    0, 0,  0,    0, 0, 0,  0,    0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0,    0, 1,  1,  100, 1, 0,  0,    0, 1, 0, 0, 0, 0)); // last -> RUN
    vecs.push_back(mk(0,  100, 0,  0,    0, 0, 1,  1,  100, 0, 0, 0, 0, 0)); // DRAIN
    vecs.push_back(mk(0,  200, 0,  0,    0, 0, 0,  0,    0, 0, 0, 0, 1, 0)); // DONE
    vecs.push_back(mk(0,  300, 0,  0,    0, 0, 0,  0,    0, 0, 0, 0, 1, 0));
    c = vecs.size();
    // Mid-drain reset run
    vecs.push_back(mk(0,    0, 0,  0,    0, 0, 0,  0,    0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0,    0, 1,  1,  100, 0, 0,  0,    0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0,    0, 1,  2, 3000, 1, 0,  0,    0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0,    0, 0,  0,    0, 0, 1,  1,  100, 1, 0, 0, 0, 0)); // in DRAIN

    do_reset("rst0");
    run_range(0, a - 1, "fill");

    // Pause: a due note is held for 50 cycles, released one cycle after unpause.
    apply(mk(1, 5500, 1, 3, 6000, 0, 0, 0, 0, 1, 1, 1, 0, 0), "pause_push");
    for (int i = 0; i < 50; i++)
      apply(mk(1, 5500, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0), $sformatf("paused[%0d]", i));
    apply(mk(0, 5500, 0, 0, 0, 0, 1, 3, 6000, 0, 1, 1, 0, 0), "unpause");
    apply(mk(0, 5500, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), "after_unpause");

    do_reset("rst1");
    run_range(a, b - 1, "order");

    do_reset("rst2");
    run_range(b, c - 1, "end");

    do_reset("rst3");
    run_range(c, vecs.size() - 1, "drain");
    // Asynchronous reset while a strobe is out and a note is still buffered.
    reset = 1'b1;
    #1;
    $display("mid_drain_reset: en=%0d cnt=%0d nt=%0d", en, count, note_time);
    check_reset_outputs("mid_drain_reset");
    #2;
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Sits between the chart/metadata loader and SC_block.
- Buffers note records (fret mask plus note time) that arrive over a valid/ready link.
- Releases each note to the scoring stage as a one-cycle event once CL_block's song_time comes within a lookahead window of the note's time.
- Drives metadata_request so the loader keeps the buffer topped up, and flags end-of-song.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- TIME_W, 16, width of song_time and note_time (ms units).
- FRET_W, 5, fret mask width.
- LOOKAHEAD, 1000, release a note when song_time + LOOKAHEAD >= note_time.

Ports:
- clk  in  1  system clock (CLK100MHZ domain).
- reset  in  1  asynchronous, active-high; clears all state.
- pause  in  1  high = song paused; no releases.
- song_time  in  TIME_W  current song position from CL_block.
- in_valid  in  1  loader offers a record.
- in_ready  out  1  scheduler can accept a record.
- in_fret  in  FRET_W  record fret mask.
- in_time  in  TIME_W  record note time.
- in_last  in  1  record is the final note of the chart.
- metadata_request  out  1  level; asks the loader for more records.
- en  out  1  one-cycle note-release strobe to SC_block.
- fret  out  FRET_W  fret mask of the released note; valid when en=1.
- note_time  out  TIME_W  time of the released note; valid when en=1.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- song_done  out  1  all records, including the last, have been released.
- order_err  out  1  sticky; a non-monotonic record was dropped.

Behaviour:
- Reset values: en=0, fret=0, note_time=0, count=0, in_ready=0, metadata_request=0, song_done=0, order_err=0; FIFO pointers 0; state IDLE. Reset mid-operation discards buffered notes immediately.
- FSM states and transitions:
  - IDLE -> FILL unconditionally on the first clock after reset deasserts.
  - FILL: metadata_request=1. Go to RUN when count==DEPTH, or on the edge accepting an in_last record (then last_seen=1).
  - RUN: metadata_request=1 when count<DEPTH/2 and last_seen=0. Go to DRAIN when an in_last record is accepted.
  - DRAIN: metadata_request=0; releases continue. Go to DONE when count==0 and no push is pending.
  - DONE: song_done=1; stays until reset.
- Accept rule: in_ready = !full && state!=IDLE && state!=DONE && !last_seen. A handshake occurs when in_valid && in_ready on a rising edge.
  - Full status is evaluated on the registered count at the start of the cycle. There is no bypass: push-while-full is impossible even if a pop happens that cycle.
- Ordering check:
  - Record accepted with in_time < time of the previous accepted record: the record is consumed but not written, and order_err is set.
  - Equal times are legal (chords may be split across records).
  - If the dropped record had in_last=1, last_seen is still set.
- Release rule: pop when count>0, pause=0, state is RUN or DRAIN, and {1'b0,song_time}+LOOKAHEAD >= {1'b0,head_time}.
  - The compare is TIME_W+1 bits wide, so there is no wraparound.
  - At most one pop per cycle.
- Release timing: en, fret and note_time are registered and appear the cycle after the pop condition holds.
  - Several due notes leave on consecutive cycles.
  - A note that is already late is still released; there is no drop.
- Simultaneous push and pop: count is unchanged, and both pointers advance modulo DEPTH.
- Pause: freezes releases only; pushes continue. A release strobe already registered completes.
- Empty FIFO: no en, even when song_time exceeds every stored time.

Optional Feature:
- Macro: NOTE_SCHED_LATE_CNT_EN.
- Defined:
  - Adds output late_count [7:0], reset 0.
  - Increments, saturating at 255, on each release whose head_time < song_time, i.e. the note was already past due at release.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package ghffe_pkg holds:
  - TIME_W and FRET_W defaults.
  - Scheduler state enum (IDLE, FILL, RUN, DRAIN, DONE).
  - note_rec_t struct {fret, time}.
- One sub-module: note_fifo, a synchronous DEPTH x (FRET_W+TIME_W) buffer with push, pop, full, empty and count.
- FSM, ordering check and release compare stay in note_scheduler.

Test Plan (bench uses DEPTH=4):
- Fill: after reset, offer times 100, 200, 300, 400 with song_time=0 -> all four accepted, count=4, state RUN, in_ready=0, metadata_request=0, no en.
- Release: with the FIFO holding 100…400, ramp song_time 0→3000 -> en pulses for 100 at song_time 0, 200 at 0, 300 at 0, 400 at 0 (all within LOOKAHEAD=1000), each on a successive cycle, with note_time 100, 200, 300, 400 in order.
- Lookahead: hold a single note at time 5000 with song_time=3999 -> no en; step song_time to 4000 -> en on the next cycle with note_time=5000 and the fret matching.
- Pause: a note is due while pause=1 -> no en for 50 cycles; drop pause -> en one cycle later.
- Order error: push 500 then 400 -> 400 is consumed but not stored, count=1, order_err=1 and stays 1.
- End: push 100 with in_last=1, then advance song_time -> state DRAIN, en for 100, song_done=1, in_ready=0; assert reset mid-DRAIN in a separate run -> all outputs at reset values immediately.
